// File: rtl/ysyx_22041461_ifu_if.sv
// Instruction-memory bus of the ysyx_22041461 fetch unit.
// The request and response share one valid/ready style handshake bundle;
// the fetch unit is the master and the instruction memory the slave.
interface ysyx_22041461_ifu_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req_valid,
    output imem_addr,
    input  imem_req_ready,
    input  imem_resp_valid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req_valid,
    input  imem_addr,
    output imem_req_ready,
    output imem_resp_valid,
    output imem_rdata
  );
endinterface

// File: rtl/ysyx_22041461_ifu.sv
// Instruction-fetch unit of the ysyx_22041461 RV64 pipeline.
// Keeps the fetch PC, issues one instruction request at a time, buffers the
// returned instruction for decode and drops wrong-path responses after a
// redirect from decode.
// Optional feature macro: YSYX_22041461_PC_ALIGN_CHK_EN enables detection of
// a misaligned fetch PC, which is reported to decode as a marker entry
// instead of being fetched.
//
// state  | meaning
// S_REQ  | idle, may issue a request when the output buffer is free
// S_WAIT | one request outstanding, waiting for its response
module ysyx_22041461_ifu #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       IF_ctrl,
  input  logic [63:0]                next_pc,
  input  logic                       ID_ready,
  ysyx_22041461_ifu_if.master        imem,
  output logic [31:0]                inst,
  output logic [63:0]                pc,
  output logic                       IF_valid_out,
  output logic                       misalign
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic {
    S_REQ  = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t      state;
  logic [63:0] fetch_pc;
  logic [63:0] req_pc;
  logic        kill;
  logic        out_valid;
  logic [31:0] inst_q;
  logic [63:0] pc_q;
  logic        free;
  logic        fetch_ok;
  logic        accept;

`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
  logic        mis_q;
  logic        mis_done;
  logic        pc_misaligned;

  assign pc_misaligned  = |fetch_pc[1:0];
  // A misaligned PC is never sent to memory; fetch parks until a redirect.
  assign fetch_ok       = !pc_misaligned;
  assign imem.imem_addr = fetch_pc;
  assign misalign       = mis_q;
`else
  assign fetch_ok       = 1'b1;
  assign imem.imem_addr = {fetch_pc[63:2], 2'b00};
  assign misalign       = 1'b0;
`endif

  // The buffer can take a new entry if it is empty or being consumed now.
  assign free                = !out_valid || ID_ready;
  assign imem.imem_req_valid = !rst && (state == S_REQ) && free && fetch_ok;
  assign accept              = imem.imem_req_valid && imem.imem_req_ready;

  assign inst         = inst_q;
  assign pc           = pc_q;
  assign IF_valid_out = out_valid;

  // Fetch FSM, fetch PC, wrong-path kill flag and the decode output buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_REQ;
      fetch_pc  <= RESET_PC;
      req_pc    <= '0;
      kill      <= 1'b0;
      out_valid <= 1'b0;
      inst_q    <= NOP;
      pc_q      <= '0;
`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
      mis_q     <= 1'b0;
      mis_done  <= 1'b0;
`endif
    end else if (IF_ctrl) begin
      // Redirect wins over everything; whatever is in flight becomes wrong-path.
      fetch_pc  <= next_pc;
      out_valid <= 1'b0;
`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
      mis_done  <= 1'b0;
`endif
      case (state)
        S_REQ: begin
          if (accept) begin
            req_pc <= fetch_pc;
            state  <= S_WAIT;
            kill   <= 1'b1;
          end
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            // The stale response lands right now, so nothing is left to kill.
            state <= S_REQ;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
      endcase
    end else begin
      if (ID_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (accept) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + 64'd4;
            state    <= S_WAIT;
          end
`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
          else if (pc_misaligned && free && !mis_done) begin
            // Present the marker once, then stall until decode redirects.
            out_valid <= 1'b1;
            inst_q    <= NOP;
            pc_q      <= fetch_pc;
            mis_q     <= 1'b1;
            mis_done  <= 1'b1;
          end
`endif
        end
        S_WAIT: begin
          if (imem.imem_resp_valid) begin
            state <= S_REQ;
            if (kill) begin
              kill <= 1'b0;
            end else begin
              // A load overrides a same-cycle consume, keeping the new entry valid.
              out_valid <= 1'b1;
              inst_q    <= imem.imem_rdata;
              pc_q      <= req_pc;
`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
              mis_q     <= 1'b0;
`endif
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22041461_ifu.sv
`timescale 1ns/1ps
// Testbench for ysyx_22041461_ifu: directed scenarios plus a randomized run,
// all delivered instructions compared against a program-order stream model.
module tb_ysyx_22041461_ifu;
  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        IF_ctrl;
  logic [63:0] next_pc;
  logic        ID_ready;
  logic [31:0] inst;
  logic [63:0] pc;
  logic        IF_valid_out;
  logic        misalign;

  ysyx_22041461_ifu_if bus ();

  ysyx_22041461_ifu #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .rst          (rst),
    .IF_ctrl      (IF_ctrl),
    .next_pc      (next_pc),
    .ID_ready     (ID_ready),
    .imem         (bus.master),
    .inst         (inst),
    .pc           (pc),
    .IF_valid_out (IF_valid_out),
    .misalign     (misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int consumed = 0;

  // memory model state
  logic        pend;
  logic [63:0] pend_addr;
  int          pend_lat;
  int          lat_max;

  // values sampled in the cycle that the last tick() covered
  logic        s_reqv, s_acc, s_resp, s_valid, s_mis;
  logic [63:0] s_addr, s_pc;
  logic [31:0] s_inst;

  // stream model: next program-order PC decode should receive
  logic [63:0] exp_pc;
  logic        hold_prev;
  logic [63:0] hold_pc;
  logic [31:0] hold_inst;

  function automatic logic [31:0] memf(input logic [63:0] a);
    if (a == 64'h8000_0000) return 32'h0050_0093;
    if (a == 64'h8000_0004) return 32'hDEAD_BEEF;
    return (a[31:0] * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  // One clock cycle: sample at negedge, score, then drive memory after posedge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    s_reqv  = bus.imem_req_valid;
    s_acc   = bus.imem_req_valid && bus.imem_req_ready;
    s_addr  = bus.imem_addr;
    s_resp  = bus.imem_resp_valid;
    s_valid = IF_valid_out;
    s_pc    = pc;
    s_inst  = inst;
    s_mis   = misalign;
    if (rst) begin
      checks++;
      if (s_reqv !== 1'b0) begin
        errors++;
        $display("FAIL req_valid_in_reset: got %b want 0", s_reqv);
      end
      exp_pc    = RESET_PC;
      hold_prev = 1'b0;
    end else begin
      if (s_acc) begin
        checks++;
        if (pend) begin
          errors++;
          $display("FAIL one_outstanding: accept at %h while %h pending", s_addr, pend_addr);
        end
      end
      if (hold_prev) begin
        checks++;
        if (s_valid !== 1'b1 || s_pc !== hold_pc || s_inst !== hold_inst) begin
          errors++;
          $display("FAIL hold_stable: got v=%b pc=%h inst=%h want v=1 pc=%h inst=%h",
                   s_valid, s_pc, s_inst, hold_pc, hold_inst);
        end
      end
      if (s_valid === 1'b1 && ID_ready) begin
        checks++;
        if (s_mis === 1'b1) begin
          if (s_inst !== NOP || s_pc[1:0] == 2'b00) begin
            errors++;
            $display("FAIL misalign_entry: got pc=%h inst=%h want misaligned pc inst=%h",
                     s_pc, s_inst, NOP);
          end
        end else if (s_pc !== exp_pc || s_inst !== memf(s_pc)) begin
          errors++;
          $display("FAIL deliver: got pc=%h inst=%h want pc=%h inst=%h",
                   s_pc, s_inst, exp_pc, memf(exp_pc));
        end
        exp_pc = s_pc + 64'd4;
        consumed++;
      end
      if (IF_ctrl) exp_pc = next_pc;
      hold_prev = s_valid && !ID_ready && !IF_ctrl;
      hold_pc   = s_pc;
      hold_inst = s_inst;
    end
    @(posedge clk);
    #1;
    if (s_resp) bus.imem_resp_valid = 1'b0;
    if (s_acc) begin
      pend      = 1'b1;
      pend_addr = s_addr;
      pend_lat  = (lat_max > 0) ? int'($urandom_range(lat_max, 0)) : 0;
    end
    if (pend) begin
      if (pend_lat == 0) begin
        bus.imem_resp_valid = 1'b1;
        bus.imem_rdata      = memf(pend_addr);
        pend                = 1'b0;
      end else begin
        pend_lat--;
      end
    end
  endtask

  task automatic do_reset();
    rst                 = 1'b1;
    IF_ctrl             = 1'b0;
    pend                = 1'b0;
    bus.imem_resp_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; IF_ctrl = 1'b0; ID_ready = 1'b1; bus.imem_req_ready = 1'b1;
    pend = 1'b0; bus.imem_resp_valid = 1'b0; lat_max = 0;
    repeat (3) tick();
    checks++;
    if (IF_valid_out !== 1'b0 || inst !== NOP || pc !== 64'd0 || misalign !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b inst=%h pc=%h mis=%b want v=0 inst=%h pc=0 mis=0",
               IF_valid_out, inst, pc, misalign, NOP);
    end
    checks++;
    if (bus.imem_addr !== RESET_PC) begin
      errors++;
      $display("FAIL reset_addr: got %h want %h", bus.imem_addr, RESET_PC);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (s_reqv !== 1'b1 || s_addr !== RESET_PC) begin
      errors++;
      $display("FAIL first_request: got v=%b addr=%h want v=1 addr=%h", s_reqv, s_addr, RESET_PC);
    end
  endtask

  task automatic test_basic_fetch();
    logic [63:0] addrs [3];
    int n_acc = 0;
    int acc_cyc = -1;
    int val_cyc = -1;
    logic [63:0] val_pc = '0;
    ID_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_max = 0;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (s_acc && n_acc < 3) begin
        addrs[n_acc] = s_addr;
        if (n_acc == 0) acc_cyc = cyc;
        n_acc++;
      end
      if (s_valid && val_cyc < 0) begin
        val_cyc = cyc;
        val_pc  = s_pc;
      end
    end
    checks++;
    if (n_acc < 3) begin
      errors++;
      $display("FAIL basic_accepts: got %0d accepts want 3", n_acc);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (addrs[i] !== RESET_PC + 64'(4 * i)) begin
          errors++;
          $display("FAIL basic_addr%0d: got %h want %h", i, addrs[i], RESET_PC + 64'(4 * i));
        end
      end
    end
    checks++;
    if (val_cyc - acc_cyc != 2 || val_pc !== RESET_PC) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles pc=%h want 2 cycles pc=%h",
               val_cyc - acc_cyc, val_pc, RESET_PC);
    end
  endtask

  task automatic test_backpressure();
    logic found = 1'b0;
    ID_ready = 1'b0; bus.imem_req_ready = 1'b1; lat_max = 0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_valid;
    end
    checks++;
    if (!found || s_inst !== 32'h0050_0093 || s_pc !== RESET_PC) begin
      errors++;
      $display("FAIL bp_first: got v=%b inst=%h pc=%h want v=1 inst=00500093 pc=%h",
               found, s_inst, s_pc, RESET_PC);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (s_reqv !== 1'b0 || s_valid !== 1'b1 || s_inst !== 32'h0050_0093 || s_pc !== RESET_PC) begin
        errors++;
        $display("FAIL bp_stall: got req=%b v=%b inst=%h pc=%h want req=0 v=1 inst=00500093 pc=%h",
                 s_reqv, s_valid, s_inst, s_pc, RESET_PC);
      end
    end
    ID_ready = 1'b1;
    tick();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_valid;
    end
    checks++;
    if (!found || s_pc !== RESET_PC + 64'd4) begin
      errors++;
      $display("FAIL bp_next: got v=%b pc=%h want v=1 pc=%h", found, s_pc, RESET_PC + 64'd4);
    end
  endtask

  task automatic test_redirect_wait();
    logic found = 1'b0;
    logic saw_bad = 1'b0;
    logic got_acc = 1'b0;
    logic [63:0] acc_addr = '0;
    ID_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_max = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_acc && (s_addr == RESET_PC + 64'd4);
    end
    // hold the 0xDEADBEEF response back one cycle so the redirect lands in WAIT
    bus.imem_resp_valid = 1'b0;
    pend = 1'b1; pend_addr = RESET_PC + 64'd4; pend_lat = 0;
    IF_ctrl = 1'b1; next_pc = 64'h8000_1000;
    tick();
    IF_ctrl = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (s_valid && s_inst == 32'hDEAD_BEEF) saw_bad = 1'b1;
      if (s_acc && !got_acc) begin got_acc = 1'b1; acc_addr = s_addr; end
      found = s_valid;
    end
    checks++;
    if (acc_addr !== 64'h8000_1000) begin
      errors++;
      $display("FAIL rw_req_addr: got %h want 0000000080001000", acc_addr);
    end
    checks++;
    if (!found || s_pc !== 64'h8000_1000 || saw_bad) begin
      errors++;
      $display("FAIL rw_deliver: got v=%b pc=%h bad=%b want v=1 pc=0000000080001000 bad=0",
               found, s_pc, saw_bad);
    end
  endtask

  task automatic test_redirect_accept_resp();
    logic found = 1'b0;
    ID_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_max = 0;
    do_reset();
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_resp;
    end
    IF_ctrl = 1'b1; next_pc = 64'h8000_2000;
    tick();
    IF_ctrl = 1'b0;
    checks++;
    if (s_acc !== 1'b1) begin
      errors++;
      $display("FAIL ra_accept_cycle: got acc=%b want 1", s_acc);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_valid;
    end
    checks++;
    if (!found || s_pc !== 64'h8000_2000) begin
      errors++;
      $display("FAIL ra_deliver_a: got v=%b pc=%h want v=1 pc=0000000080002000", found, s_pc);
    end
    found = s_acc;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_acc;
    end
    IF_ctrl = 1'b1; next_pc = 64'h8000_3000;
    tick();
    IF_ctrl = 1'b0;
    checks++;
    if (s_resp !== 1'b1) begin
      errors++;
      $display("FAIL ra_resp_cycle: got resp=%b want 1", s_resp);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_valid;
    end
    checks++;
    if (!found || s_pc !== 64'h8000_3000) begin
      errors++;
      $display("FAIL ra_deliver_b: got v=%b pc=%h want v=1 pc=0000000080003000", found, s_pc);
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    ID_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_max = 0;
    do_reset();
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      found = s_acc && (s_addr == RESET_PC + 64'd4);
    end
    // response to 0x80000004 arrives in the first cycle after reset is released
    bus.imem_resp_valid = 1'b0;
    pend = 1'b1; pend_addr = RESET_PC + 64'd4; pend_lat = 1;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (s_resp !== 1'b1 || s_acc !== 1'b1 || s_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rm_restart: got resp=%b acc=%b addr=%h want resp=1 acc=1 addr=%h",
               s_resp, s_acc, s_addr, RESET_PC);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      found = s_valid;
    end
    checks++;
    if (!found || s_pc !== RESET_PC || s_inst !== 32'h0050_0093) begin
      errors++;
      $display("FAIL rm_deliver: got v=%b pc=%h inst=%h want v=1 pc=%h inst=00500093",
               found, s_pc, s_inst, RESET_PC);
    end
  endtask

`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
  task automatic test_misalign();
    logic found = 1'b0;
    logic got_acc = 1'b0;
    logic [63:0] acc_addr = '0;
    ID_ready = 1'b1; bus.imem_req_ready = 1'b0; lat_max = 0;
    do_reset();
    IF_ctrl = 1'b1; next_pc = 64'h8000_0002;
    tick();
    IF_ctrl = 1'b0; ID_ready = 1'b0; bus.imem_req_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (s_reqv !== 1'b0 || s_valid !== 1'b1 || s_mis !== 1'b1 ||
          s_pc !== 64'h8000_0002 || s_inst !== NOP) begin
        errors++;
        $display("FAIL ma_marker: got req=%b v=%b mis=%b pc=%h inst=%h want 0 1 1 0000000080000002 %h",
                 s_reqv, s_valid, s_mis, s_pc, s_inst, NOP);
      end
    end
    ID_ready = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (s_reqv !== 1'b0 || s_valid !== 1'b0) begin
        errors++;
        $display("FAIL ma_stall: got req=%b v=%b want 0 0", s_reqv, s_valid);
      end
    end
    IF_ctrl = 1'b1; next_pc = 64'h8000_0100;
    tick();
    IF_ctrl = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      tick();
      if (s_acc && !got_acc) begin got_acc = 1'b1; acc_addr = s_addr; end
      found = s_valid;
    end
    checks++;
    if (acc_addr !== 64'h8000_0100 || !found || s_pc !== 64'h8000_0100 || s_mis !== 1'b0) begin
      errors++;
      $display("FAIL ma_resume: got addr=%h v=%b pc=%h mis=%b want 0000000080000100 1 0000000080000100 0",
               acc_addr, found, s_pc, s_mis);
    end
  endtask
`endif

  task automatic test_random();
    int start;
    ID_ready = 1'b1; bus.imem_req_ready = 1'b1; lat_max = 3;
    do_reset();
    start = consumed;
    for (int i = 0; i < 3000; i++) begin
      ID_ready           = ($urandom_range(3, 0) != 0);
      bus.imem_req_ready = ($urandom_range(2, 0) != 0);
      IF_ctrl            = ($urandom_range(22, 0) == 0);
      next_pc            = RESET_PC + 64'({$urandom_range(1023, 0), 2'b00});
      tick();
    end
    IF_ctrl = 1'b0;
    checks++;
    if (consumed - start < 100) begin
      errors++;
      $display("FAIL random_progress: got %0d delivered want at least 100", consumed - start);
    end
  endtask

  initial begin
    rst = 1'b1; IF_ctrl = 1'b0; ID_ready = 1'b0; next_pc = '0;
    bus.imem_req_ready = 1'b0; bus.imem_resp_valid = 1'b0; bus.imem_rdata = '0;
    pend = 1'b0; pend_addr = '0; pend_lat = 0; lat_max = 0;
    exp_pc = RESET_PC; hold_prev = 1'b0; hold_pc = '0; hold_inst = '0;
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_redirect_wait();
    test_redirect_accept_resp();
    test_reset_mid();
`ifdef YSYX_22041461_PC_ALIGN_CHK_EN
    test_misalign();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
